// File: rtl/systolic_pkg.sv
// Shared sizes, FSM encoding, job payload and lane-slicing helpers for the
// systolic array job sequencer.
package systolic_pkg;

  localparam int unsigned N           = 3;
  localparam int unsigned DW          = 8;
  localparam int unsigned CW          = 16;
  localparam int unsigned DEF_TIMEOUT = 64;

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LW = N * DW;
  localparam int unsigned MW = N * N * DW;
  localparam int unsigned RW = N * N * CW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_WAIT,
    ST_DONE
  } ctrl_state_t;

  typedef struct packed {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
  } job_t;

  // Column k of A: lane i carries A[i][k].
  function automatic logic [LW-1:0] col_of(input logic [MW-1:0] a_mat, input logic [KW-1:0] k);
    logic [LW-1:0] lanes;
    lanes = '0;
    for (int unsigned i = 0; i < N; i++)
      lanes[i*DW +: DW] = a_mat[(i*N + 32'(k))*DW +: DW];
    return lanes;
  endfunction

  // Row k of B: lane j carries B[k][j].
  function automatic logic [LW-1:0] row_of(input logic [MW-1:0] b_mat, input logic [KW-1:0] k);
    logic [LW-1:0] lanes;
    lanes = '0;
    for (int unsigned j = 0; j < N; j++)
      lanes[j*DW +: DW] = b_mat[(32'(k)*N + j)*DW +: DW];
    return lanes;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl.sv
// Job sequencer: loads one operand pair, clears and streams it through the
// systolic array, then holds the products behind a valid/ready handshake.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] a_mat,
  input  logic [MW-1:0] b_mat,
  output logic          arr_rst,
  output logic [LW-1:0] arr_a,
  output logic [LW-1:0] arr_b,
  input  logic [RW-1:0] arr_c,
  input  logic          arr_valid,
  output logic [RW-1:0] res_c,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          err
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  ctrl_state_t    state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [WDW-1:0] wd_q, wd_d;
  job_t           job_q;

  logic           accept, capture, abort;
  logic           arr_rst_d, res_valid_d;
  logic [LW-1:0]  arr_a_d, arr_b_d;

  assign in_ready = (state_q == ST_IDLE) & rst;

  // Next state, counters and the values the output registers load next.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wd_d        = wd_q;
    accept      = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    arr_rst_d   = 1'b1;
    arr_a_d     = '0;
    arr_b_d     = '0;
    res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        k_d     = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (k_q == KW'(N - 1)) begin
          wd_d    = '0;
          state_d = ST_WAIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_WAIT: begin
        // Completion wins over the watchdog on the same edge.
        if (arr_valid) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    arr_rst_d   = (state_d != ST_CLEAR);
    res_valid_d = (state_d == ST_DONE);
    if (state_d == ST_FEED) begin
      arr_a_d = col_of(job_q.a, k_d);
      arr_b_d = row_of(job_q.b, k_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      wd_q      <= '0;
      job_q     <= '0;
      arr_rst   <= 1'b0;
      arr_a     <= '0;
      arr_b     <= '0;
      res_c     <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wd_q      <= wd_d;
      arr_rst   <= arr_rst_d;
      arr_a     <= arr_a_d;
      arr_b     <= arr_b_d;
      res_valid <= res_valid_d;
      err       <= abort;
      if (accept) begin
        job_q.a <= a_mat;
        job_q.b <= b_mat;
      end
      if (capture) res_c <= arr_c;
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl with a behavioural array stub that accumulates
// streamed outer products and can withhold or pre-empt its completion strobe.
module tb_systolic_array_ctrl;
  import systolic_pkg::*;

  localparam int unsigned TO       = 8;
  localparam int unsigned STUB_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [MW-1:0] a_mat, b_mat;
  logic          arr_rst;
  logic [LW-1:0] arr_a, arr_b;
  logic [RW-1:0] arr_c;
  logic          arr_valid;
  logic [RW-1:0] res_c;
  logic          res_valid, res_ready, err;

  systolic_array_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_rst(arr_rst), .arr_a(arr_a), .arr_b(arr_b),
    .arr_c(arr_c), .arr_valid(arr_valid), .res_c(res_c), .res_valid(res_valid),
    .res_ready(res_ready), .err(err)
  );

  always #5 clk = ~clk;

  // Array stub: 0 = normal, 1 = never completes, 2 = bogus completion during feed.
  int   mode = 0;
  int   acc [N][N];
  int   cnt;
  logic stale_on;

  always @(posedge clk) begin
    if (!(arr_rst && rst)) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) acc[i][j] = 0;
      cnt = 0;
      arr_valid <= 1'b0;
      stale_on  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] = acc[i][j] + int'(32'(arr_a[i*DW +: DW]) * 32'(arr_b[j*DW +: DW]));
      if (cnt < 1000) cnt = cnt + 1;
      stale_on  <= (mode == 2) && (cnt == 1 || cnt == 2);
      arr_valid <= (mode == 1) ? 1'b0 :
                   ((mode == 2) && (cnt == 1 || cnt == 2)) ? 1'b1 :
                   (cnt >= int'(N + STUB_LAT));
    end
  end

  always_comb begin
    arr_c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) arr_c[(i*N + j)*CW +: CW] = CW'(acc[i][j]);
    if (stale_on) arr_c = {(N*N){16'hdead}};
  end

  // Reference model: plain matrix arithmetic on the packed operands.
  function automatic int el(input logic [MW-1:0] m, input int i, input int j);
    return int'(32'(m[(i*N + j)*DW +: DW]));
  endfunction

  function automatic logic [RW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [RW-1:0] c;
    int s;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s = s + el(a, i, k) * el(b, k, j);
        c[(i*N + j)*CW +: CW] = CW'(s);
      end
    return c;
  endfunction

  function automatic logic [LW-1:0] exp_col(input logic [MW-1:0] a, input int k);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(el(a, i, k));
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_row(input logic [MW-1:0] b, input int k);
    logic [LW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(el(b, k, j));
    return v;
  endfunction

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [RW-1:0] last_c = '0;

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Offer a job from IDLE and follow it through CLEAR, FEED and into WAIT.
  task automatic start_job(input logic [MW-1:0] a, input logic [MW-1:0] b);
    chk("idle_in_ready", RW'(in_ready), RW'(1));
    a_mat = a; b_mat = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("clear_arr_rst", RW'(arr_rst), RW'(0));
    chk("clear_lanes", RW'({arr_a, arr_b}), RW'(0));
    chk("clear_in_ready", RW'(in_ready), RW'(0));
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      chk("feed_a", RW'(arr_a), RW'(exp_col(a, k)));
      chk("feed_b", RW'(arr_b), RW'(exp_row(b, k)));
      chk("feed_arr_rst", RW'(arr_rst), RW'(1));
      chk("feed_res_valid", RW'(res_valid), RW'(0));
    end
    @(posedge clk); #1;
    chk("flush_lanes", RW'({arr_a, arr_b}), RW'(0));
  endtask

  // Wait for the result, hold it under backpressure for bp cycles, then consume it.
  task automatic finish_job(input logic [RW-1:0] exp_c, input int bp);
    int c;
    c = 0;
    while (!res_valid && c < 30) begin
      @(posedge clk); #1;
      c++;
    end
    chk("res_valid_rise", RW'(res_valid), RW'(1));
    chk("res_c", res_c, exp_c);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      a_mat = MW'({$urandom, $urandom, $urandom});
      b_mat = MW'({$urandom, $urandom, $urandom});
      @(posedge clk); #1;
      chk("bp_res_valid", RW'(res_valid), RW'(1));
      chk("bp_res_c", res_c, exp_c);
      chk("bp_in_ready", RW'(in_ready), RW'(0));
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post_res_valid", RW'(res_valid), RW'(0));
    chk("post_in_ready", RW'(in_ready), RW'(1));
    chk("post_err", RW'(err), RW'(0));
    last_c = exp_c;
  endtask

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [RW-1:0] c;
    int            bp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] nom, ident, ra, rb;
    logic [RW-1:0] nom_c, seq_c;
    int first, pulses, rv_seen;

    nom   = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    ident = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    nom_c = {16'd150, 16'd126, 16'd102, 16'd96, 16'd81, 16'd66, 16'd42, 16'd36, 16'd30};
    seq_c = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

    tbl[0] = '{a: nom,   b: nom, c: nom_c, bp: 0};
    tbl[1] = '{a: nom,   b: nom, c: nom_c, bp: 0};
    tbl[2] = '{a: ident, b: nom, c: seq_c, bp: 0};
    tbl[3] = '{a: nom,   b: nom, c: nom_c, bp: 5};

    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; a_mat = '0; b_mat = '0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", RW'(in_ready), RW'(0));
    chk("rst_arr_rst", RW'(arr_rst), RW'(0));
    chk("rst_lanes", RW'({arr_a, arr_b}), RW'(0));
    chk("rst_res", RW'({res_valid, err}), RW'(0));
    chk("rst_res_c", res_c, RW'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_arr_rst", RW'(arr_rst), RW'(1));

    for (int t = 0; t < 4; t++) begin
      start_job(tbl[t].a, tbl[t].b);
      finish_job(tbl[t].c, tbl[t].bp);
    end

    // Completion strobe with garbage data during FEED must not be captured.
    mode = 2;
    start_job(ident, nom);
    finish_job(seq_c, 1);

    // Array that never completes: watchdog abort.
    mode = 1;
    start_job(nom, nom);
    first = 0; pulses = 0; rv_seen = 0;
    for (int c = 1; c <= int'(TO) + 6; c++) begin
      @(posedge clk); #1;
      if (res_valid) rv_seen = 1;
      if (err) begin
        pulses++;
        if (first == 0) begin
          first = c;
          chk("abort_in_ready", RW'(in_ready), RW'(1));
        end
      end
    end
    chk("abort_cycle", RW'(first), RW'(TO));
    chk("abort_pulses", RW'(pulses), RW'(1));
    chk("abort_no_result", RW'(rv_seen), RW'(0));
    chk("abort_res_c_held", res_c, last_c);
    chk("abort_idle", RW'(in_ready), RW'(1));

    // Reset asserted in FEED with k = 1.
    mode = 0;
    a_mat = nom; b_mat = nom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("midrst_pre_a", RW'(arr_a), RW'(exp_col(nom, 1)));
    rst = 1'b0;
    #1;
    chk("midrst_lanes", RW'({arr_a, arr_b}), RW'(0));
    chk("midrst_arr_rst", RW'(arr_rst), RW'(0));
    chk("midrst_in_ready", RW'(in_ready), RW'(0));
    chk("midrst_res_c", res_c, RW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", RW'(in_ready), RW'(1));
    start_job(nom, nom);
    finish_job(nom_c, 0);

    // Random jobs against the reference model.
    for (int r = 0; r < 6; r++) begin
      ra = MW'({$urandom, $urandom, $urandom});
      rb = MW'({$urandom, $urandom, $urandom});
      mode = (r % 3 == 2) ? 2 : 0;
      start_job(ra, rb);
      finish_job(matmul(ra, rb), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
